// File: rtl/data_sram_if.sv
// Data-side SRAM interface: handshaked issue, in-order tracking FIFO, load extension,
// store lane generation, misalignment detection and flush. Optional DATA_SRAM_IF_PERF_EN adds perf counters.
module data_sram_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_wr,
  input  logic [2:0]        req_sel,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              req_ready,
  input  logic              flush,
  output logic              stall,
  output logic              adel,
  output logic              ades,
  output logic [ADDR_W-1:0] badvaddr,
  output logic              rsp_valid,
  output logic              rsp_wr,
  output logic [31:0]       rsp_rdata,
  output logic              data_sram_req,
  output logic              data_sram_wr,
  output logic [1:0]        data_sram_size,
  output logic [3:0]        data_sram_wstrb,
  output logic [ADDR_W-1:0] data_sram_addr,
  output logic [31:0]       data_sram_wdata,
  input  logic              data_sram_addr_ok,
  input  logic [31:0]       data_sram_rdata,
  input  logic              data_sram_data_ok
`ifdef DATA_SRAM_IF_PERF_EN
  ,
  output logic [31:0]       perf_req_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Tracking FIFO: one entry per access accepted by memory, oldest at rd_ptr
  logic             ent_wr     [DEPTH];
  logic [2:0]       ent_sel    [DEPTH];
  logic [1:0]       ent_off    [DEPTH];
  logic             ent_cancel [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic [1:0] acc_size;
  logic       misaligned;
  logic [3:0] store_strb;
  logic       push;
  logic       pop;
  logic       rsp_fire;

  function automatic logic [31:0] load_ext(input logic [2:0]  sel,
                                           input logic [1:0]  off,
                                           input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (sel)
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = {16'h0000, h};
      3'b011:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'h00_0000, b};
      default: r = word;
    endcase
    return r;
  endfunction

  // Access decode, misalignment and issue handshake
  always_comb begin
    acc_size = SZ_WORD;
    case (req_sel)
      3'b001, 3'b010: acc_size = SZ_HALF;
      3'b011, 3'b100: acc_size = SZ_BYTE;
      default:        acc_size = SZ_WORD;
    endcase

    misaligned = ((acc_size == SZ_HALF) && req_addr[0]) ||
                 ((acc_size == SZ_WORD) && (req_addr[1:0] != 2'b00));

    data_sram_req = req_valid & ~misaligned & ~flush & ~rst & (count < DEPTH_CNT);
    push          = data_sram_req & data_sram_addr_ok;
    req_ready     = push | (req_valid & misaligned);
    stall         = req_valid & ~req_ready;

    adel     = req_valid & misaligned & ~req_wr;
    ades     = req_valid & misaligned & req_wr;
    badvaddr = (adel | ades) ? req_addr : '0;

    pop      = data_sram_data_ok & (count != '0);
    rsp_fire = pop & ~ent_cancel[rd_ptr] & ~flush;
  end

  // Memory-side request fields
  always_comb begin
    store_strb = 4'b1111;
    data_sram_wdata = req_wdata;
    case (acc_size)
      SZ_BYTE: begin
        store_strb      = 4'b0001 << req_addr[1:0];
        data_sram_wdata = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        store_strb      = req_addr[1] ? 4'b1100 : 4'b0011;
        data_sram_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        store_strb      = 4'b1111;
        data_sram_wdata = req_wdata;
      end
    endcase
    data_sram_wr    = req_wr;
    data_sram_size  = acc_size;
    data_sram_wstrb = req_wr ? store_strb : 4'b0000;
    data_sram_addr  = req_addr & ~ADDR_W'(3);
  end

  // FIFO state; flush marks every in-flight entry so its data_ok is swallowed
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        ent_wr[i]     <= 1'b0;
        ent_sel[i]    <= 3'b000;
        ent_off[i]    <= 2'b00;
        ent_cancel[i] <= 1'b0;
      end
    end else begin
      if (flush) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          ent_cancel[i] <= 1'b1;
        end
      end
      if (push) begin
        ent_wr[wr_ptr]     <= req_wr;
        ent_sel[wr_ptr]    <= req_sel;
        ent_off[wr_ptr]    <= req_addr[1:0];
        ent_cancel[wr_ptr] <= 1'b0;
        wr_ptr             <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Registered response, one cycle after the pop
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_wr    <= 1'b0;
      rsp_rdata <= 32'h0;
    end else begin
      rsp_valid <= rsp_fire;
      rsp_wr    <= rsp_fire & ent_wr[rd_ptr];
      rsp_rdata <= (rsp_fire && !ent_wr[rd_ptr]) ?
                   load_ext(ent_sel[rd_ptr], ent_off[rd_ptr], data_sram_rdata) : 32'h0;
    end
  end

`ifdef DATA_SRAM_IF_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_req_cnt   <= 32'h0;
      perf_stall_cnt <= 32'h0;
    end else begin
      if (push) begin
        perf_req_cnt <= perf_req_cnt + 32'd1;
      end
      if (stall) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/data_sram_if.md
Name: data_sram_if

Overview:
Data-side memory interface for the 5-stage core, placed between the MEM stage and the data SRAM port. It replaces the purely combinational bridge with a handshaked, buffered interface. It supports up to DEPTH outstanding requests, in-order responses, load extension and store byte-lane generation. It detects misaligned addresses (AdEL/AdES) and drops responses on pipeline flush.

Parameters:
ADDR_W, 32, address width in bits; minimum 2.
DEPTH, 2, maximum outstanding requests; power of 2, minimum 2.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  MEM stage presents an access
req_wr  in  1  1 = store, 0 = load
req_sel  in  3  000 word; 001 half signed; 010 half unsigned; 011 byte signed; 100 byte unsigned; other codes = word
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-aligned
req_ready  out  1  request consumed this cycle
flush  in  1  cancel all in-flight requests
stall  out  1  req_valid & ~req_ready
adel  out  1  misaligned load (combinational)
ades  out  1  misaligned store (combinational)
badvaddr  out  ADDR_W  req_addr when adel or ades, else 0
rsp_valid  out  1  registered response
rsp_wr  out  1  response belongs to a store
rsp_rdata  out  32  extended load data; 0 for stores
data_sram_req  out  1  memory request
data_sram_wr  out  1  memory write
data_sram_size  out  2  0 byte, 1 half, 2 word
data_sram_wstrb  out  4  byte-lane write enables
data_sram_addr  out  ADDR_W  req_addr with bits [1:0] forced to 0
data_sram_wdata  out  32  store data replicated onto lanes
data_sram_addr_ok  in  1  memory accepted the request
data_sram_rdata  in  32  read data
data_sram_data_ok  in  1  response for the oldest outstanding request

Behaviour:
- Misaligned access: half with addr[0]=1, or word with addr[1:0]!=0.
  - adel/ades assert when req_valid is high.
  - req_ready=1 in the same cycle; no memory request is issued and nothing is queued.
- Issue: data_sram_req = req_valid & ~misaligned & ~flush & ~rst & (count<DEPTH). fire = data_sram_req & data_sram_addr_ok. req_ready = fire | (req_valid & misaligned).
- Store lanes and data:
  - byte: wstrb = 1<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - half: wstrb = addr[1] ? 1100 : 0011, wdata = {2{wdata[15:0]}}.
  - word: wstrb = 1111.
  - Loads drive wstrb = 0000.
- Tracking FIFO: DEPTH entries of {wr, sel, addr[1:0], cancel}, read/write pointers of log2(DEPTH) bits that wrap, and a count of 0..DEPTH.
  - Push on fire; pop on data_sram_data_ok when count>0.
  - Simultaneous push and pop leaves count unchanged.
  - data_ok with count==0 is ignored: no pop, no response.
- Full: count==DEPTH blocks issue (stall=1) until a data_ok frees a slot. The slot freed in cycle N becomes usable in cycle N+1.
- Response: one cycle after a pop of a non-cancelled entry, rsp_valid=1 for exactly one cycle.
  - rsp_wr is taken from the popped entry.
  - rsp_rdata: selected lane of data_sram_rdata, sign- or zero-extended per sel; full word for word loads; 0 for stores.
- Flush: sets cancel on every valid entry in the same edge. Cancelled entries still pop on data_ok but produce no rsp_valid. No new request is issued while flush=1.
- A data_ok arriving in the same cycle as flush pops the head, and that entry is suppressed.
- Reset, including mid-transaction:
  - count, pointers, cancel bits and rsp_valid/rsp_wr/rsp_rdata clear to 0.
  - data_sram_req is forced to 0 while rst=1.
  - A data_ok arriving after reset release with count==0 is ignored.

Optional Feature:
DATA_SRAM_IF_PERF_EN:
- Defined: adds outputs perf_req_cnt[31:0] (increments on each fire) and perf_stall_cnt[31:0] (increments each cycle stall=1). Both are cleared by rst and wrap modulo 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Load byte signed: addr=0x1003, rdata=0x80FF_FF7F, addr_ok=1, data_ok next cycle -> wstrb=0000, size=0, sram addr=0x1000, rsp_valid one cycle after data_ok, rsp_rdata=0xFFFF_FF80.
- Store half: addr=0x2002, wdata=0x0000_BEEF -> wstrb=1100, wdata=0xBEEF_BEEF, size=1, later rsp_valid=1 with rsp_wr=1 and rsp_rdata=0.
- Misaligned word load at 0x3001 -> adel=1, badvaddr=0x3001, req_ready=1, data_sram_req=0, count unchanged, no response.
- DEPTH=2: three back-to-back loads, data_ok withheld -> third load sees stall=1; data_ok in cycle N -> third issued in N+1, three responses delivered in order.
- Two loads outstanding, flush pulse, then two data_ok -> no rsp_valid, count returns to 0; next load responds normally.
- rst asserted with 2 outstanding, then a stray data_ok -> rsp_valid stays 0, count=0; with DATA_SRAM_IF_PERF_EN, both perf counters read 0 after reset.
